// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage load/store sequencer driving the data-cache req/ack port.
// Define MEMCTRL_PERF_EN to build the saturating stall-cycle performance counter.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        dc_req,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_ack,
  input  logic [31:0] dc_rdata,
  output logic        stall_m,
  output logic [31:0] rdata_w,
  output logic        ld_done,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dc_req_q, dc_req_d;
  logic        dc_we_q, dc_we_d;
  logic [31:0] dc_addr_q, dc_addr_d;
  logic [31:0] dc_wdata_q, dc_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ld_done_q, ld_done_d;
  logic        bus_err_q, bus_err_d;

  logic acc;
  logic mis;
  logic start;
  logic timeout_hit;

  assign acc         = valid_m & (mem_read_m | mem_write_m);
  assign mis         = acc & (addr_m[1:0] != 2'b00);
  assign start       = acc & ~mis;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (dc_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Misaligned accesses are only flagged; they never stall or reach the cache.
  always_comb begin
    stall_m      = 1'b0;
    misalign_exc = 1'b0;
    case (state_q)
      IDLE: begin
        stall_m      = start;
        misalign_exc = mis;
      end
      BUSY:    stall_m = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    dc_req_d   = dc_req_q;
    dc_we_d    = dc_we_q;
    dc_addr_d  = dc_addr_q;
    dc_wdata_d = dc_wdata_q;
    rdata_d    = rdata_q;
    ld_done_d  = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dc_req_d   = 1'b1;
          dc_we_d    = mem_write_m;
          dc_addr_d  = addr_m;
          dc_wdata_d = wdata_m;
          cnt_d      = 8'd0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // An ack arriving on the last allowed cycle still completes normally.
        if (dc_ack) begin
          dc_req_d = 1'b0;
          if (!dc_we_q) begin
            rdata_d   = dc_rdata;
            ld_done_d = 1'b1;
          end
        end else if (timeout_hit) begin
          dc_req_d  = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      dc_req_q   <= 1'b0;
      dc_we_q    <= 1'b0;
      dc_addr_q  <= 32'd0;
      dc_wdata_q <= 32'd0;
      rdata_q    <= 32'd0;
      ld_done_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dc_req_q   <= dc_req_d;
      dc_we_q    <= dc_we_d;
      dc_addr_q  <= dc_addr_d;
      dc_wdata_q <= dc_wdata_d;
      rdata_q    <= rdata_d;
      ld_done_q  <= ld_done_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dc_req   = dc_req_q;
  assign dc_we    = dc_we_q;
  assign dc_addr  = dc_addr_q;
  assign dc_wdata = dc_wdata_q;
  assign rdata_w  = rdata_q;
  assign ld_done  = ld_done_q;
  assign bus_err  = bus_err_q;

`ifdef MEMCTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_m && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: two instances (TIMEOUT 8 and 4) share stimulus and are
// checked every cycle against a transaction-schedule model; honours MEMCTRL_PERF_EN.
module tb_mem_stage_ctrl;

  localparam int T0 = 8;
  localparam int T1 = 4;
`ifdef MEMCTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        mis;
    logic        req;
    logic        chk;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ldDone;
    logic        busErr;
    logic [31:0] rdata;
    logic [31:0] perf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, mem_read_m, mem_write_m;
  logic [31:0] addr_m, wdata_m;
  logic        dc_ack;
  logic [31:0] dc_rdata;

  logic [1:0]  dcReq, dcWe, stallM, ldDone, misExc, busErr;
  logic [31:0] dcAddr [2];
  logic [31:0] dcWdata [2];
  logic [31:0] rdataW [2];
  logic [31:0] stallCyc [2];

  int          checks = 0;
  int          failures = 0;
  bit          expValid = 1'b0;
  exp_t        expv [2];
  logic [31:0] rdataM [2];
  logic [31:0] perfM [2];
  int          tmo [2];

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(T0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .dc_req(dcReq[0]), .dc_we(dcWe[0]), .dc_addr(dcAddr[0]), .dc_wdata(dcWdata[0]),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata), .stall_m(stallM[0]), .rdata_w(rdataW[0]),
    .ld_done(ldDone[0]), .misalign_exc(misExc[0]), .bus_err(busErr[0]),
    .stall_cycles(stallCyc[0])
  );

  mem_stage_ctrl #(.TIMEOUT(T1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .dc_req(dcReq[1]), .dc_we(dcWe[1]), .dc_addr(dcAddr[1]), .dc_wdata(dcWdata[1]),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata), .stall_m(stallM[1]), .rdata_w(rdataW[1]),
    .ld_done(ldDone[1]), .misalign_exc(misExc[1]), .bus_err(busErr[1]),
    .stall_cycles(stallCyc[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t quietExp(input int i);
    exp_t e;
    e.stall  = 1'b0;
    e.mis    = 1'b0;
    e.req    = 1'b0;
    e.chk    = 1'b0;
    e.we     = 1'b0;
    e.addr   = 32'd0;
    e.wdata  = 32'd0;
    e.ldDone = 1'b0;
    e.busErr = 1'b0;
    e.rdata  = rdataM[i];
    e.perf   = PERF_EN ? perfM[i] : 32'd0;
    return e;
  endfunction

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (expValid) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("dut%0d.stall_m", i), {31'd0, stallM[i]}, {31'd0, expv[i].stall});
        checkOutput($sformatf("dut%0d.misalign_exc", i), {31'd0, misExc[i]}, {31'd0, expv[i].mis});
        checkOutput($sformatf("dut%0d.dc_req", i), {31'd0, dcReq[i]}, {31'd0, expv[i].req});
        checkOutput($sformatf("dut%0d.ld_done", i), {31'd0, ldDone[i]}, {31'd0, expv[i].ldDone});
        checkOutput($sformatf("dut%0d.bus_err", i), {31'd0, busErr[i]}, {31'd0, expv[i].busErr});
        checkOutput($sformatf("dut%0d.rdata_w", i), rdataW[i], expv[i].rdata);
        checkOutput($sformatf("dut%0d.stall_cycles", i), stallCyc[i], expv[i].perf);
        if (expv[i].chk) begin
          checkOutput($sformatf("dut%0d.dc_we", i), {31'd0, dcWe[i]}, {31'd0, expv[i].we});
          checkOutput($sformatf("dut%0d.dc_addr", i), dcAddr[i], expv[i].addr);
          checkOutput($sformatf("dut%0d.dc_wdata", i), dcWdata[i], expv[i].wdata);
        end
      end
    end
  end

  // One instruction presented for one cycle, then the cache answers ackN cycles
  // after BUSY entry (0 = never); resetAt >= 0 pulls rst_n low on that cycle.
  task automatic applyStimulus(input bit vld, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdat, input int ackN, input int resetAt);
    bit   acc, mis, isLoad, live;
    int   kc [2];
    bit   acked [2];
    int   minK, maxK, last;
    exp_t e;
    acc    = vld && (rd || wr);
    mis    = acc && (addr[1:0] != 2'b00);
    live   = acc && !mis;
    isLoad = rd && !wr;
    for (int i = 0; i < 2; i++) begin
      acked[i] = (ackN >= 1) && (ackN <= tmo[i]);
      kc[i]    = acked[i] ? ackN : tmo[i];
    end
    minK = (kc[0] < kc[1]) ? kc[0] : kc[1];
    maxK = (kc[0] > kc[1]) ? kc[0] : kc[1];
    if (!live) last = 0;
    else if (resetAt >= 0) last = resetAt + 2;
    else last = maxK + 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      dc_ack      = 1'b0;
      dc_rdata    = $urandom;
      addr_m      = $urandom;
      wdata_m     = $urandom;
      valid_m     = 1'b0;
      mem_read_m  = 1'($urandom_range(0, 1));
      mem_write_m = 1'($urandom_range(0, 1));
      if (c == 0) begin
        valid_m     = vld;
        mem_read_m  = rd;
        mem_write_m = wr;
        addr_m      = addr;
        wdata_m     = wdata;
        dc_ack      = ($urandom_range(0, 3) == 0);
      end else if (live && c <= minK + 1 && (resetAt < 0 || c < resetAt)) begin
        valid_m = 1'($urandom_range(0, 1));
      end
      if (live && c == ackN) begin
        dc_ack   = 1'b1;
        dc_rdata = rdat;
      end
      if (resetAt >= 0 && c == resetAt) rst_n = 1'b0;
      if (resetAt >= 0 && c == resetAt + 1) rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (resetAt >= 0 && c == resetAt) begin
          rdataM[i] = 32'd0;
          perfM[i]  = 32'd0;
        end
        e = quietExp(i);
        if (resetAt >= 0 && c >= resetAt) begin
          e.chk = (c == resetAt);
        end else if (c == 0) begin
          e.stall = live;
          e.mis   = mis;
        end else if (live && c <= kc[i]) begin
          e.stall = 1'b1;
          e.req   = 1'b1;
          e.chk   = 1'b1;
          e.we    = wr;
          e.addr  = addr;
          e.wdata = wdata;
        end else if (live && c == kc[i] + 1) begin
          if (acked[i] && isLoad) begin
            rdataM[i] = rdat;
            e.ldDone  = 1'b1;
          end
          if (!acked[i]) begin
            rdataM[i] = 32'd0;
            e.busErr  = 1'b1;
          end
        end
        e.rdata = rdataM[i];
        if (e.stall && perfM[i] != 32'hFFFF_FFFF) perfM[i] = perfM[i] + 32'd1;
        expv[i] = e;
      end
    end
  endtask

  initial begin
    logic [31:0] r, a;
    int          sel, kind, ackN, resetAt;
    bit          vld, rd, wr;

    tmo[0] = T0;
    tmo[1] = T1;
    rst_n = 1'b0;
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
    addr_m = 32'd0; wdata_m = 32'd0; dc_ack = 1'b0; dc_rdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      rdataM[i] = 32'd0;
      perfM[i]  = 32'd0;
      expv[i]   = quietExp(i);
      expv[i].chk = 1'b1;
    end
    expValid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) expv[i].chk = 1'b0;

    // Minimum-latency load, then a 3-cycle load: 2 + 4 stall cycles.
    applyStimulus(1, 1, 0, 32'h0000_0100, 32'h1111_1111, 32'hDEAD_BEEF, 1, -1);
    checkOutput("lit.load_rdata", rdataW[0], 32'hDEAD_BEEF);
    applyStimulus(1, 1, 0, 32'h0000_0104, 32'h2222_2222, 32'hCAFE_F00D, 3, -1);
    checkOutput("lit.stall_cycles", stallCyc[0], PERF_EN ? 32'd6 : 32'd0);
    // Store with ack after 5 cycles; the TIMEOUT=4 copy aborts instead.
    applyStimulus(1, 0, 1, 32'h0000_0200, 32'h1234_5678, 32'h0BAD_0BAD, 5, -1);
    checkOutput("lit.store_keeps_rdata", rdataW[0], 32'hCAFE_F00D);
    checkOutput("lit.abort_clears_rdata", rdataW[1], 32'd0);
    applyStimulus(1, 1, 0, 32'h0000_0102, 32'h0, 32'h0, 1, -1);
    applyStimulus(1, 1, 0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 0, -1);
    // Ack on the 4th BUSY cycle beats the TIMEOUT=4 abort.
    applyStimulus(1, 1, 0, 32'h0000_0304, 32'h0, 32'hA5A5_0F0F, 4, -1);
    checkOutput("lit.ack_wins_rdata", rdataW[1], 32'hA5A5_0F0F);
    applyStimulus(1, 1, 0, 32'h0000_0400, 32'h0, 32'h7777_7777, 3, 2);
    checkOutput("lit.reset_rdata", rdataW[0], 32'd0);
    applyStimulus(1, 1, 1, 32'h0000_0500, 32'h9999_0000, 32'h4444_4444, 2, -1);

    for (int n = 0; n < 80; n++) begin
      sel  = $urandom_range(0, 19);
      r    = $urandom;
      a    = {r[31:2], 2'b00};
      kind = $urandom_range(0, 2);
      vld  = 1'b1;
      rd   = (kind != 1);
      wr   = (kind != 0);
      ackN = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 10);
      resetAt = -1;
      if (sel < 3) a[1:0] = 2'($urandom_range(1, 3));
      else if (sel == 3) vld = 1'b0;
      else if (sel == 4) begin rd = 1'b0; wr = 1'b0; end
      else if (sel == 5) resetAt = $urandom_range(1, 5);
      applyStimulus(vld, rd, wr, a, $urandom, $urandom, ackN, resetAt);
      if ($urandom_range(0, 2) == 0) applyStimulus(0, 0, 0, 32'd0, 32'd0, 32'd0, 0, -1);
    end

    @(posedge clk);
    expValid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the memory stage of the pipelined processor. Sits between the EX/MEM pipeline register outputs and the data-cache port. Runs each load/store through a req/ack handshake, and holds the pipeline with `stall_m` while the access is outstanding. Also detects misaligned word accesses and cache timeouts, and hands load data to the MEM/WB register.

## Interface
Parameters:
- `TIMEOUT`, 64: max cycles in BUSY without `dc_ack` before abort; legal range 2..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_m` in 1: EX/MEM register holds a live instruction.
- `mem_read_m` in 1: instruction is a load.
- `mem_write_m` in 1: instruction is a store.
- `addr_m` in 32: ALU result from EX/MEM, the byte address.
- `wdata_m` in 32: store data from EX/MEM.
- `dc_req` out 1: cache request.
- `dc_we` out 1: 1 = write.
- `dc_addr` out 32: cache address.
- `dc_wdata` out 32: cache write data.
- `dc_ack` in 1: cache completion, single-cycle pulse.
- `dc_rdata` in 32: load data, valid with `dc_ack`.
- `stall_m` out 1: hold EX/MEM and all earlier pipeline registers.
- `rdata_w` out 32: captured load data for MEM/WB.
- `ld_done` out 1: one-cycle pulse, load data valid on `rdata_w`.
- `misalign_exc` out 1: misaligned access flagged.
- `bus_err` out 1: one-cycle pulse on timeout abort.
- `stall_cycles` out 32: performance counter (see Configuration).

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- Access detect: `acc = valid_m & (mem_read_m | mem_write_m)`.
  - If both read and write are set, the access is treated as a store.
- Alignment: `mis = acc & (addr_m[1:0] != 0)`.

IDLE:
- `misalign_exc = mis`, combinational. No request is issued and no stall is raised; the instruction advances normally.
- If `acc & ~mis`:
  - `stall_m = 1`, combinational.
  - Register `dc_addr <= addr_m`, `dc_wdata <= wdata_m`, `dc_we <= mem_write_m`, `dc_req <= 1`.
  - Clear the timeout counter and go to BUSY.

BUSY:
- `stall_m = 1`.
- `dc_req`, `dc_we`, `dc_addr`, `dc_wdata` stay stable until ack.
- Counter increments every cycle.
- On `dc_ack`:
  - `dc_req <= 0`.
  - If the access was a load, `rdata_w <= dc_rdata` and `ld_done <= 1`.
  - Go to DONE.
- Else if counter == `TIMEOUT-1`:
  - `dc_req <= 0`, `bus_err <= 1`, `rdata_w <= 0`.
  - Go to DONE.
- If `dc_ack` and timeout happen in the same cycle, ack wins and `bus_err` stays 0.

DONE:
- `stall_m = 0`, so the pipeline advances at the end of this cycle.
- `ld_done` / `bus_err` are high for this cycle only.
- Go unconditionally to IDLE. The next instruction is evaluated there.

Other rules:
- `dc_ack` outside BUSY is ignored.
- Changes on `valid_m`/`addr_m` while in BUSY are ignored, since the outputs are latched.

## Timing
- Reset values: FSM = IDLE, counter = 0, `dc_req` = 0, `dc_we` = 0, `dc_addr` = 0, `dc_wdata` = 0, `rdata_w` = 0, `ld_done` = 0, `bus_err` = 0, `stall_cycles` = 0.
  - Combinational outputs `stall_m` and `misalign_exc` are 0 while `valid_m` is 0.
- Minimum access takes 3 cycles: detect (IDLE) → BUSY with ack on its first cycle → DONE. `stall_m` is high for 2 cycles.
- With ack N cycles after BUSY entry (N ≥ 1), `stall_m` is high for N+1 cycles.
- Timeout: BUSY lasts exactly `TIMEOUT` cycles, then DONE with `bus_err`.
- Back-to-back accesses: IDLE is revisited between accesses, so there is no request in the DONE cycle. The second `dc_req` rises 2 cycles after the first ack.
- Reset mid-operation: asynchronous return to reset values. `dc_req` drops without waiting for ack, and any late ack is ignored.

## Configuration
- Macro: `MEMCTRL_PERF_EN`.
- Defined: `stall_cycles` increments on every cycle with `stall_m = 1`. It saturates at 0xFFFFFFFF and is cleared only by reset.
- Undefined: the counter logic is not built and `stall_cycles` is tied to 0.

## Test plan
- Load at 0x100, ack 1 cycle after BUSY entry with `dc_rdata` = 0xDEADBEEF → `stall_m` high 2 cycles, `dc_we` = 0, `rdata_w` = 0xDEADBEEF with `ld_done` pulse in DONE.
- Store 0x12345678 to 0x200, ack delayed 5 cycles → `dc_req` held 5 cycles with stable `dc_addr`/`dc_wdata`/`dc_we` = 1, `stall_m` high 6 cycles, `ld_done` = 0.
- Load at 0x102 → `misalign_exc` = 1 in the same cycle, `dc_req` never rises, `stall_m` = 0.
- `TIMEOUT` = 4, no ack → `bus_err` pulse after exactly 4 BUSY cycles, `rdata_w` = 0. Repeat with ack on the 4th cycle → no `bus_err`, data captured.
- Assert `rst_n` = 0 in the 2nd BUSY cycle → `dc_req` and `stall_m` drop immediately; an ack after reset release causes no `ld_done`.
- With `MEMCTRL_PERF_EN`: two loads with 1-cycle and 3-cycle ack → `stall_cycles` = 6. Without the macro → `stall_cycles` = 0.
